// File: rtl/key_pulse_repeater.sv
// key_pulse_repeater
// Multi-channel push-button front end for the clock/alarm setting logic.
// Each channel synchronises and debounces a raw button level. It emits a
// one-cycle pulse on the debounced press and can auto-repeat that pulse
// while the button stays held. All channels are independent and share clk.

`timescale 1ns/1ps

module key_pulse_repeater #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int REPEAT_DELAY    = 16,
  parameter int REPEAT_PERIOD   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CHANNELS-1:0] input_signal,
  input  logic [CHANNELS-1:0] repeat_en,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] held
);

  localparam int CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = $clog2(TMR_MAX);

  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_e;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_chan
    logic             sync1_q;
    logic             sync2_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             held_q;
    logic             held_d;
    logic             pulse_q;
    logic             pulse_d;
    state_e           state_q;
    state_e           state_d;
    logic [TMR_W-1:0] timer_q;
    logic [TMR_W-1:0] timer_d;
    logic             rise;
    logic             fall;

    // Debounce: accept a new level only after it has differed from held
    // for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts.
    always_comb begin
      held_d = held_q;
      cnt_d  = '0;
      rise   = 1'b0;
      fall   = 1'b0;
      if (sync2_q != held_q) begin
        if (cnt_q == CNT_LAST) begin
          held_d = sync2_q;
          rise   = sync2_q;
          fall   = ~sync2_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    // Press/repeat FSM: a release always wins over a due repeat pulse, and
    // every state change restarts the repeat timer from zero.
    always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      pulse_d = 1'b0;
      if (fall) begin
        state_d = IDLE;
        timer_d = '0;
      end else begin
        case (state_q)
          IDLE: begin
            timer_d = '0;
            if (rise) begin
              state_d = DELAY;
              pulse_d = 1'b1;
            end
          end
          DELAY: begin
            if (!repeat_en[ch]) begin
              timer_d = '0;
            end else if (timer_q == DELAY_LAST) begin
              state_d = REPEAT;
              timer_d = '0;
              pulse_d = 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          REPEAT: begin
            if (!repeat_en[ch]) begin
              state_d = DELAY;
              timer_d = '0;
            end else if (timer_q == PERIOD_LAST) begin
              timer_d = '0;
              pulse_d = 1'b1;
            end else begin
              timer_d = timer_q + 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            timer_d = '0;
          end
        endcase
      end
    end

    // Channel state register: synchroniser, debounce, FSM, timer and outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= 1'b0;
        sync2_q <= 1'b0;
        cnt_q   <= '0;
        held_q  <= 1'b0;
        pulse_q <= 1'b0;
        state_q <= IDLE;
        timer_q <= '0;
      end else begin
        sync1_q <= input_signal[ch];
        sync2_q <= sync1_q;
        cnt_q   <= cnt_d;
        held_q  <= held_d;
        pulse_q <= pulse_d;
        state_q <= state_d;
        timer_q <= timer_d;
      end
    end

    assign pulse[ch] = pulse_q;
    assign held[ch]  = held_q;
  end

endmodule

// File: tb/tb_key_pulse_repeater.sv
// Self-checking bench for key_pulse_repeater.
// Stimulus is a per-sample waveform for each channel. The expected held/pulse
// streams come from a behavioural model: run-length debounce on raw samples,
// plus pulse timing derived from runs of enabled samples while held.

`timescale 1ns/1ps

module tb_key_pulse_repeater;

  localparam int CH   = 4;
  localparam int D    = 4;
  localparam int RD   = 16;
  localparam int RP   = 8;
  localparam int MAXN = 700;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] input_signal;
  logic [CH-1:0] repeat_en;
  logic [CH-1:0] pulse;
  logic [CH-1:0] held;

  int compared   = 0;
  int mismatched = 0;

  // Stimulus waveforms and expected outputs, indexed [channel][edge number].
  bit wave  [CH][MAXN+1];
  bit enw   [CH][MAXN+1];
  bit exp_p [CH][MAXN+1];
  bit exp_h [CH][MAXN+1];

  key_pulse_repeater #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .input_signal(input_signal),
    .repeat_en   (repeat_en),
    .pulse       (pulse),
    .held        (held)
  );

  always #5 clk = ~clk;

  // Clear all stimulus arrays.
  task automatic clear_stim();
    for (int ch = 0; ch < CH; ch++) begin
      for (int e = 0; e <= MAXN; e++) begin
        wave[ch][e] = 1'b0;
        enw[ch][e]  = 1'b0;
      end
    end
  endtask

  // Drive the inputs that the DUT will sample at edge e.
  task automatic drive_inputs(input int e);
    for (int ch = 0; ch < CH; ch++) begin
      input_signal[ch] = wave[ch][e];
      repeat_en[ch]    = enw[ch][e];
    end
  endtask

  // Behavioural model. A level is accepted once the raw samples differ from
  // the current level for D consecutive samples; acceptance at sample s shows
  // on the outputs after edge s+2 (two synchroniser stages). While held, a
  // pulse fires on the rise, then after RD consecutive enabled samples, then
  // after every RP consecutive enabled samples. A disabled sample restarts
  // the full RD wait. No pulse is due on the edge where held falls.
  function automatic void build_expected(input int n);
    for (int ch = 0; ch < CH; ch++) begin
      bit lvl;
      int run;
      bit lev_after [MAXN+1];
      lvl = 1'b0;
      run = 0;
      lev_after[0] = 1'b0;
      for (int s = 1; s <= n; s++) begin
        if (wave[ch][s] != lvl) run++;
        else run = 0;
        if (run == D) begin
          lvl = ~lvl;
          run = 0;
        end
        lev_after[s] = lvl;
      end
      for (int e = 0; e <= MAXN; e++) begin
        exp_p[ch][e] = 1'b0;
        exp_h[ch][e] = (e >= 3 && e <= n) ? lev_after[e-2] : 1'b0;
      end
      for (int e = 1; e <= n; e++) begin
        if (exp_h[ch][e] && !exp_h[ch][e-1]) begin
          bit repeating;
          int en_run;
          exp_p[ch][e] = 1'b1;
          repeating = 1'b0;
          en_run = 0;
          for (int t = e + 1; t <= n && exp_h[ch][t]; t++) begin
            if (enw[ch][t]) begin
              en_run++;
              if (en_run == (repeating ? RP : RD)) begin
                exp_p[ch][t] = 1'b1;
                repeating = 1'b1;
                en_run = 0;
              end
            end else begin
              en_run = 0;
              repeating = 1'b0;
            end
          end
        end
      end
    end
  endfunction

  // Reset holds everything at zero regardless of inputs; after release with
  // idle inputs nothing happens for 1 us.
  task automatic test_reset();
    $display("[TB] test_reset");
    rst_n = 1'b0;
    input_signal = '0;
    repeat_en = '0;
    #1;
    for (int i = 0; i < 9; i++) begin
      input_signal = 4'($urandom);
      repeat_en    = 4'($urandom);
      compared++;
      if (pulse !== 4'b0000 || held !== 4'b0000) begin
        mismatched++;
        $display("[TB] FAIL reset_hold t=%0t: got pulse=%b held=%b, want 0000/0000", $time, pulse, held);
      end
      #10;
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    input_signal = '0;
    repeat_en = '0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (pulse !== 4'b0000 || held !== 4'b0000) begin
        mismatched++;
        $display("[TB] FAIL reset_idle cycle %0d: got pulse=%b held=%b, want 0000/0000", i, pulse, held);
      end
    end
  endtask

  // ch0 held for 5 us with repeat disabled: exactly one pulse.
  task automatic test_short_press();
    int n;
    int npulse [CH];
    $display("[TB] test_short_press");
    n = 520;
    clear_stim();
    for (int e = 1; e <= 500; e++) wave[0][e] = 1'b1;
    build_expected(n);
    for (int ch = 0; ch < CH; ch++) npulse[ch] = 0;
    for (int e = 1; e <= n; e++) begin
      drive_inputs(e);
      @(posedge clk);
      #1;
      for (int ch = 0; ch < CH; ch++) begin
        if (pulse[ch]) npulse[ch]++;
        compared++;
        if (pulse[ch] !== exp_p[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL short_press pulse ch%0d edge %0d: got %b want %b", ch, e, pulse[ch], exp_p[ch][e]);
        end
        compared++;
        if (held[ch] !== exp_h[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL short_press held ch%0d edge %0d: got %b want %b", ch, e, held[ch], exp_h[ch][e]);
        end
      end
    end
    for (int ch = 0; ch < CH; ch++) begin
      compared++;
      if (npulse[ch] !== ((ch == 0) ? 1 : 0)) begin
        mismatched++;
        $display("[TB] FAIL short_press count ch%0d: got %0d want %0d", ch, npulse[ch], (ch == 0) ? 1 : 0);
      end
    end
  endtask

  // A 3-sample blip on ch1 is ignored; a 4-sample one is accepted.
  task automatic test_glitch();
    int n;
    $display("[TB] test_glitch");
    n = 50;
    clear_stim();
    for (int e = 5; e <= 7; e++) wave[1][e] = 1'b1;
    for (int e = 20; e <= 23; e++) wave[1][e] = 1'b1;
    build_expected(n);
    for (int e = 1; e <= n; e++) begin
      drive_inputs(e);
      @(posedge clk);
      #1;
      for (int ch = 0; ch < CH; ch++) begin
        compared++;
        if (pulse[ch] !== exp_p[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL glitch pulse ch%0d edge %0d: got %b want %b", ch, e, pulse[ch], exp_p[ch][e]);
        end
        compared++;
        if (held[ch] !== exp_h[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL glitch held ch%0d edge %0d: got %b want %b", ch, e, held[ch], exp_h[ch][e]);
        end
      end
      if (e == 25) begin
        compared++;
        if (held[1] !== 1'b1 || pulse[1] !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL glitch accept edge 25: got held=%b pulse=%b want 1/1", held[1], pulse[1]);
        end
      end
    end
  endtask

  // ch2 held 40 cycles past the first pulse with repeat enabled.
  task automatic test_auto_repeat();
    int n;
    $display("[TB] test_auto_repeat");
    n = 70;
    clear_stim();
    for (int e = 1; e <= n; e++) enw[2][e] = 1'b1;
    for (int e = 1; e <= 41; e++) wave[2][e] = 1'b1;
    build_expected(n);
    for (int e = 1; e <= n; e++) begin
      drive_inputs(e);
      @(posedge clk);
      #1;
      for (int ch = 0; ch < CH; ch++) begin
        compared++;
        if (pulse[ch] !== exp_p[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL auto_repeat pulse ch%0d edge %0d: got %b want %b", ch, e, pulse[ch], exp_p[ch][e]);
        end
        compared++;
        if (held[ch] !== exp_h[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL auto_repeat held ch%0d edge %0d: got %b want %b", ch, e, held[ch], exp_h[ch][e]);
        end
      end
      if (e == 46) begin
        compared++;
        if (pulse[2] !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL auto_repeat P+40 edge 46: got %b want 1", pulse[2]);
        end
      end
    end
  endtask

  // ch3: repeat_en dropped at P+20 and raised at P+30 gives the next pulse at
  // P+46; then a release landing on a repeat edge suppresses that pulse.
  task automatic test_repeat_en_toggle();
    int n;
    $display("[TB] test_repeat_en_toggle");
    n = 100;
    clear_stim();
    for (int e = 1; e <= n; e++) enw[3][e] = 1'b1;
    for (int e = 27; e <= 36; e++) enw[3][e] = 1'b0;
    for (int e = 1; e <= 80; e++) wave[3][e] = 1'b1;
    build_expected(n);
    for (int e = 1; e <= n; e++) begin
      drive_inputs(e);
      @(posedge clk);
      #1;
      for (int ch = 0; ch < CH; ch++) begin
        compared++;
        if (pulse[ch] !== exp_p[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL en_toggle pulse ch%0d edge %0d: got %b want %b", ch, e, pulse[ch], exp_p[ch][e]);
        end
        compared++;
        if (held[ch] !== exp_h[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL en_toggle held ch%0d edge %0d: got %b want %b", ch, e, held[ch], exp_h[ch][e]);
        end
      end
      if (e == 52) begin
        compared++;
        if (pulse[3] !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL en_toggle P+46 edge 52: got %b want 1", pulse[3]);
        end
      end
    end

    n = 50;
    clear_stim();
    for (int e = 1; e <= n; e++) enw[3][e] = 1'b1;
    for (int e = 1; e <= 32; e++) wave[3][e] = 1'b1;
    build_expected(n);
    for (int e = 1; e <= n; e++) begin
      drive_inputs(e);
      @(posedge clk);
      #1;
      for (int ch = 0; ch < CH; ch++) begin
        compared++;
        if (pulse[ch] !== exp_p[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL release_on_repeat pulse ch%0d edge %0d: got %b want %b", ch, e, pulse[ch], exp_p[ch][e]);
        end
        compared++;
        if (held[ch] !== exp_h[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL release_on_repeat held ch%0d edge %0d: got %b want %b", ch, e, held[ch], exp_h[ch][e]);
        end
      end
      if (e == 38) begin
        compared++;
        if (pulse[3] !== 1'b0 || held[3] !== 1'b0) begin
          mismatched++;
          $display("[TB] FAIL release_on_repeat edge 38: got pulse=%b held=%b want 0/0", pulse[3], held[3]);
        end
      end
    end
  endtask

  // Reset asserted mid-repeat on ch2 with the button still held.
  task automatic test_reset_mid_repeat();
    int n;
    $display("[TB] test_reset_mid_repeat");
    n = 80;
    clear_stim();
    for (int e = 1; e <= n; e++) enw[2][e] = 1'b1;
    for (int e = 1; e <= 60; e++) wave[2][e] = 1'b1;
    build_expected(n);
    for (int e = 1; e <= 33; e++) begin
      drive_inputs(e);
      @(posedge clk);
      #1;
      for (int ch = 0; ch < CH; ch++) begin
        compared++;
        if (pulse[ch] !== exp_p[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL pre_reset pulse ch%0d edge %0d: got %b want %b", ch, e, pulse[ch], exp_p[ch][e]);
        end
        compared++;
        if (held[ch] !== exp_h[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL pre_reset held ch%0d edge %0d: got %b want %b", ch, e, held[ch], exp_h[ch][e]);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    compared++;
    if (pulse !== 4'b0000 || held !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_immediate: got pulse=%b held=%b want 0000/0000", pulse, held);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      compared++;
      if (pulse !== 4'b0000 || held !== 4'b0000) begin
        mismatched++;
        $display("[TB] FAIL mid_reset_hold cycle %0d: got pulse=%b held=%b want 0000/0000", i, pulse, held);
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= n; e++) begin
      drive_inputs(e);
      @(posedge clk);
      #1;
      for (int ch = 0; ch < CH; ch++) begin
        compared++;
        if (pulse[ch] !== exp_p[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL post_reset pulse ch%0d edge %0d: got %b want %b", ch, e, pulse[ch], exp_p[ch][e]);
        end
        compared++;
        if (held[ch] !== exp_h[ch][e]) begin
          mismatched++;
          $display("[TB] FAIL post_reset held ch%0d edge %0d: got %b want %b", ch, e, held[ch], exp_h[ch][e]);
        end
      end
    end
  endtask

  // Random press/glitch/enable patterns on all channels; the last pass drives
  // identical stimulus on every channel.
  task automatic test_random();
    int n;
    $display("[TB] test_random");
    n = 600;
    for (int iter = 0; iter < 3; iter++) begin
      clear_stim();
      for (int ch = 0; ch < CH; ch++) begin
        bit lvl;
        bit en_cur;
        int s;
        lvl = 1'($urandom);
        en_cur = 1'($urandom);
        s = 1;
        while (s <= n - 15) begin
          int len;
          len = $urandom_range(30, 1);
          for (int k = 0; k < len && s <= n - 15; k++) begin
            wave[ch][s] = lvl;
            s++;
          end
          lvl = ~lvl;
        end
        for (int e = 1; e <= n; e++) begin
          if ($urandom_range(19, 0) == 0) en_cur = ~en_cur;
          enw[ch][e] = en_cur;
        end
      end
      if (iter == 2) begin
        for (int ch = 1; ch < CH; ch++) begin
          for (int e = 0; e <= n; e++) begin
            wave[ch][e] = wave[0][e];
            enw[ch][e]  = enw[0][e];
          end
        end
      end
      build_expected(n);
      for (int e = 1; e <= n; e++) begin
        drive_inputs(e);
        @(posedge clk);
        #1;
        for (int ch = 0; ch < CH; ch++) begin
          compared++;
          if (pulse[ch] !== exp_p[ch][e]) begin
            mismatched++;
            $display("[TB] FAIL random%0d pulse ch%0d edge %0d: got %b want %b", iter, ch, e, pulse[ch], exp_p[ch][e]);
          end
          compared++;
          if (held[ch] !== exp_h[ch][e]) begin
            mismatched++;
            $display("[TB] FAIL random%0d held ch%0d edge %0d: got %b want %b", iter, ch, e, held[ch], exp_h[ch][e]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_short_press();
    test_glitch();
    test_auto_repeat();
    test_repeat_en_toggle();
    test_reset_mid_repeat();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
